// File: rtl/rv32i_pkg.sv
// RV32I encoder shared types: opcodes, kinds, ALU-op/funct3 codes, errors.
// Optional immediate range check is selected with INST_ENC_IMM_CHECK_EN.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    K_R      = 4'd0,
    K_IALU   = 4'd1,
    K_LOAD   = 4'd2,
    K_STORE  = 4'd3,
    K_BRANCH = 4'd4,
    K_JAL    = 4'd5,
    K_JALR   = 4'd6,
    K_LUI    = 4'd7,
    K_AUIPC  = 4'd8
  } inst_kind_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_KIND  = 2'b01,
    ERR_FUNCT = 2'b10,
    ERR_IMM   = 2'b11
  } err_code_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } enc_state_e;

endpackage

// File: rtl/rv32i_inst_pack.sv
// Combinational RV32I field packer and legality check.
// INST_ENC_IMM_CHECK_EN: reject immediates that do not fit their field.
module rv32i_inst_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [3:0]  i_alu_op,
  input  logic [2:0]  i_f3,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_err,
  output logic [1:0]  o_code
);

  logic w_kind_bad;
  logic w_funct_bad;
  logic w_imm_bad;
  logic w_shift;

  assign w_shift = (i_alu_op[1:0] == 2'b01);

  // field packing and funct legality per instruction kind
  always_comb begin
    o_inst      = '0;
    w_kind_bad  = 1'b0;
    w_funct_bad = 1'b0;
    case (i_kind)
      K_R: begin
        w_funct_bad = i_alu_op[3] &
                      (i_alu_op != ALU_SUB) &
                      (i_alu_op != ALU_SRA);
        o_inst = {i_alu_op[3] ? F7_ALT : F7_BASE,
                  i_rs2, i_rs1, i_alu_op[2:0],
                  i_rd, OP_R};
      end
      K_IALU: begin
        w_funct_bad = i_alu_op[3] &
                      (i_alu_op != ALU_SRA);
        if (w_shift)
          o_inst = {i_alu_op[3] ? F7_ALT : F7_BASE,
                    i_imm[4:0], i_rs1, i_alu_op[2:0],
                    i_rd, OP_IMM};
        else
          o_inst = {i_imm[11:0], i_rs1,
                    i_alu_op[2:0], i_rd, OP_IMM};
      end
      K_LOAD: begin
        w_funct_bad = !(i_f3 inside
          {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        o_inst = {i_imm[11:0], i_rs1, i_f3,
                  i_rd, OP_LOAD};
      end
      K_STORE: begin
        w_funct_bad = !(i_f3 inside
          {F3_SB, F3_SH, F3_SW});
        o_inst = {i_imm[11:5], i_rs2, i_rs1, i_f3,
                  i_imm[4:0], OP_STORE};
      end
      K_BRANCH: begin
        w_funct_bad = !(i_f3 inside
          {F3_BEQ, F3_BNE, F3_BLT,
           F3_BGE, F3_BLTU, F3_BGEU});
        o_inst = {i_imm[12], i_imm[10:5], i_rs2,
                  i_rs1, i_f3, i_imm[4:1],
                  i_imm[11], OP_BRANCH};
      end
      K_JAL: begin
        o_inst = {i_imm[20], i_imm[10:1], i_imm[11],
                  i_imm[19:12], i_rd, OP_JAL};
      end
      K_JALR: begin
        o_inst = {i_imm[11:0], i_rs1, F3_JALR,
                  i_rd, OP_JALR};
      end
      K_LUI: begin
        o_inst = {i_imm[31:12], i_rd, OP_LUI};
      end
      K_AUIPC: begin
        o_inst = {i_imm[31:12], i_rd, OP_AUIPC};
      end
      default: begin
        w_kind_bad = 1'b1;
      end
    endcase
  end

`ifdef INST_ENC_IMM_CHECK_EN
  logic w_i_ok;
  logic w_b_ok;
  logic w_j_ok;
  logic w_u_ok;
  logic w_sh_ok;

  assign w_i_ok  = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_b_ok  = ((&i_imm[31:12]) | ~(|i_imm[31:12]))
                   & ~i_imm[0];
  assign w_j_ok  = ((&i_imm[31:20]) | ~(|i_imm[31:20]))
                   & ~i_imm[0];
  assign w_u_ok  = ~(|i_imm[11:0]);
  assign w_sh_ok = ~(|i_imm[31:5]);

  // immediate representability per format
  always_comb begin
    w_imm_bad = 1'b0;
    case (i_kind)
      K_IALU:
        w_imm_bad = w_shift ? ~w_sh_ok : ~w_i_ok;
      K_LOAD, K_STORE, K_JALR:
        w_imm_bad = ~w_i_ok;
      K_BRANCH:
        w_imm_bad = ~w_b_ok;
      K_JAL:
        w_imm_bad = ~w_j_ok;
      K_LUI, K_AUIPC:
        w_imm_bad = ~w_u_ok;
      default:
        w_imm_bad = 1'b0;
    endcase
  end
`else
  assign w_imm_bad = 1'b0;
`endif

  // error code, kind error dominates funct, funct dominates imm
  always_comb begin
    o_code = ERR_NONE;
    if (w_kind_bad)
      o_code = ERR_KIND;
    else if (w_funct_bad)
      o_code = ERR_FUNCT;
    else if (w_imm_bad)
      o_code = ERR_IMM;
  end

  assign o_err = w_kind_bad | w_funct_bad | w_imm_bad;

endmodule

// File: rtl/inst_encoder.sv
// RV32I encoder: output register, IMEM address counter, halt FSM, errors.
// INST_ENC_IMM_CHECK_EN enables immediate range rejection in the packer.
module inst_encoder
  import rv32i_pkg::*;
#(
  parameter int               ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter bit               STOP_ON_ERR = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_kind,
  input  logic [3:0]        i_alu_op,
  input  logic [2:0]        i_f3,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  input  logic              i_addr_clr,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  enc_state_e        r_state;
  enc_state_e        w_state_nxt;
  logic              r_valid;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_ready;
  logic              w_accept;
  logic              w_out_hs;
  logic [31:0]       w_inst;
  logic              w_perr;
  logic [1:0]        w_pcode;

  rv32i_inst_pack u_pack (
    .i_kind   (i_kind),
    .i_alu_op (i_alu_op),
    .i_f3     (i_f3),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_imm    (i_imm),
    .o_inst   (w_inst),
    .o_err    (w_perr),
    .o_code   (w_pcode)
  );

  assign w_ready  = i_rst_n & (r_state == ST_RUN) &
                    ~i_addr_clr &
                    (~r_valid | i_inst_ready);
  assign w_accept = i_req_valid & w_ready;
  assign w_out_hs = r_valid & i_inst_ready;

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  // halt on a rejected request when configured, clear resumes
  always_comb begin
    w_state_nxt = r_state;
    if (i_addr_clr)
      w_state_nxt = ST_RUN;
    else if (STOP_ON_ERR && w_accept && w_perr)
      w_state_nxt = ST_HALT;
  end

  // output word register and address counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_addr  <= BASE_ADDR;
    end else if (i_addr_clr) begin
      r_valid <= 1'b0;
      r_addr  <= BASE_ADDR;
    end else begin
      if (w_out_hs)
        r_addr <= r_addr + ADDR_W'(4);
      if (w_accept && !w_perr) begin
        r_valid <= 1'b1;
        r_inst  <= w_inst;
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  // error pulse and sticky error code
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err <= w_accept & w_perr;
      if (w_accept && w_perr)
        r_err_code <= w_pcode;
    end
  end

  assign o_req_ready  = w_ready;
  assign o_inst_valid = r_valid;
  assign o_inst       = r_inst;
  assign o_inst_addr  = r_addr;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: transaction model plus literals.
// Honours INST_ENC_IMM_CHECK_EN when compiled with it.
module tb_inst_encoder;

  localparam bit IMM_CHK =
`ifdef INST_ENC_IMM_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        addr_clr = 1'b0;
  logic        inst_ready = 1'b1;
  logic [3:0]  kind = '0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  f3 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        req_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        err;
  logic [1:0]  err_code;

  logic        h_req_valid = 1'b0;
  logic        h_addr_clr = 1'b0;
  logic        h_inst_ready = 1'b1;
  logic        h_req_ready;
  logic        h_inst_valid;
  logic [31:0] h_inst;
  logic [31:0] h_inst_addr;
  logic        h_err;
  logic [1:0]  h_err_code;

  inst_encoder u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_kind(kind), .i_alu_op(alu_op), .i_f3(f3),
    .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .i_addr_clr(addr_clr),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst(inst), .o_inst_addr(inst_addr),
    .o_err(err), .o_err_code(err_code)
  );

  inst_encoder #(
    .ADDR_W(32), .BASE_ADDR(32'hFFFF_FFF8), .STOP_ON_ERR(1'b1)
  ) u_halt (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(h_req_valid), .o_req_ready(h_req_ready),
    .i_kind(kind), .i_alu_op(alu_op), .i_f3(f3),
    .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .i_addr_clr(h_addr_clr),
    .o_inst_valid(h_inst_valid), .i_inst_ready(h_inst_ready),
    .o_inst(h_inst), .o_inst_addr(h_inst_addr),
    .o_err(h_err), .o_err_code(h_err_code)
  );

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference encoder: returns {error code, word}, code 0 means legal.
  function automatic logic [33:0] enc(
    input logic [3:0] k, input logic [3:0] op, input logic [2:0] f,
    input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
    input logic [31:0] im);
    logic [31:0] w;
    logic [1:0]  c;
    longint      s;
    bit          fits;
    s = longint'($signed(im));
    w = '0;
    c = 2'd0;
    fits = 1'b1;
    case (k)
      4'd0: begin
        if (op[3] && op != 4'd8 && op != 4'd13) c = 2'd2;
        w = {op[3] ? 7'b0100000 : 7'b0, s2, s1, op[2:0], d, 7'b0110011};
      end
      4'd1: begin
        if (op[3] && op != 4'd13) c = 2'd2;
        if (op[1:0] == 2'b01) begin
          w = {op == 4'd13 ? 7'b0100000 : 7'b0, im[4:0], s1, op[2:0],
               d, 7'b0010011};
          fits = im < 32;
        end else begin
          w = {im[11:0], s1, op[2:0], d, 7'b0010011};
          fits = s >= -2048 && s <= 2047;
        end
      end
      4'd2: begin
        if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) c = 2'd2;
        w = {im[11:0], s1, f, d, 7'b0000011};
        fits = s >= -2048 && s <= 2047;
      end
      4'd3: begin
        if (f > 2) c = 2'd2;
        w = {im[11:5], s2, s1, f, im[4:0], 7'b0100011};
        fits = s >= -2048 && s <= 2047;
      end
      4'd4: begin
        if (f == 2 || f == 3) c = 2'd2;
        w = {im[12], im[10:5], s2, s1, f, im[4:1], im[11], 7'b1100011};
        fits = s >= -4096 && s <= 4095 && !im[0];
      end
      4'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
        fits = s >= -(64'sd1 <<< 20) && s < (64'sd1 <<< 20) && !im[0];
      end
      4'd6: begin
        w = {im[11:0], s1, 3'b000, d, 7'b1100111};
        fits = s >= -2048 && s <= 2047;
      end
      4'd7: begin
        w = {im[31:12], d, 7'b0110111};
        fits = (im % 4096) == 0;
      end
      4'd8: begin
        w = {im[31:12], d, 7'b0010111};
        fits = (im % 4096) == 0;
      end
      default: c = 2'd1;
    endcase
    if (IMM_CHK && c == 0 && !fits) c = 2'd3;
    return {c, w};
  endfunction

  // Transaction model of the default instance
  logic [31:0] m_q[$];
  logic [31:0] m_addr = 32'h0;
  bit          m_err = 1'b0;
  logic [1:0]  m_code = 2'd0;

  function automatic bit exp_ready();
    return !addr_clr && (m_q.size() == 0 || inst_ready);
  endfunction

  initial begin
    logic [33:0] r;
    bit          take;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_addr = 32'h0;
        m_err = 1'b0;
        m_code = 2'd0;
      end else if (addr_clr) begin
        m_q.delete();
        m_addr = 32'h0;
        m_err = 1'b0;
      end else begin
        take = req_valid && exp_ready();
        if (m_q.size() != 0 && inst_ready) begin
          void'(m_q.pop_front());
          m_addr = m_addr + 32'd4;
        end
        m_err = 1'b0;
        if (take) begin
          r = enc(kind, alu_op, f3, rd, rs1, rs2, imm);
          if (r[33:32] != 2'd0) begin
            m_err = 1'b1;
            m_code = r[33:32];
          end else begin
            m_q.push_back(r[31:0]);
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_ready", req_ready, exp_ready());
        chk("m_valid", inst_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("m_inst", inst, m_q[0]);
        chk("m_addr", inst_addr, m_addr);
        chk("m_err", err, m_err);
        chk("m_code", err_code, m_code);
      end
    end
  end

  task automatic wait_acc(input bit h);
    int n;
    bit ok;
    n = 0;
    forever begin
      @(negedge clk);
      ok = h ? h_req_ready : req_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 40) begin
        nvec++;
        nfail++;
        $display("FAIL accept_timeout: ready 0 for 40 cycles, required 1");
        break;
      end
    end
    if (h) h_req_valid = 1'b0;
    else req_valid = 1'b0;
  endtask

  task automatic set_req(input bit h, input logic [3:0] k,
    input logic [3:0] op, input logic [2:0] f, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    kind = k; alu_op = op; f3 = f;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    if (h) h_req_valid = 1'b1;
    else req_valid = 1'b1;
  endtask

  task automatic send(input bit h, input logic [3:0] k,
    input logic [3:0] op, input logic [2:0] f, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    @(posedge clk);
    #1;
    set_req(h, k, op, f, d, s1, s2, im);
    wait_acc(h);
  endtask

  task automatic see(input string nm, input logic [31:0] ei,
                     input logic [31:0] ea);
    @(negedge clk);
    chk({nm, "_valid"}, inst_valid, 1'b1);
    chk({nm, "_inst"}, inst, ei);
    chk({nm, "_addr"}, inst_addr, ea);
  endtask

  task automatic clear();
    @(posedge clk);
    #1 addr_clr = 1'b1;
    @(posedge clk);
    #1 addr_clr = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_code", err_code, 2'd0);
    chk("rst_h_addr", h_inst_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // directed encodings with literal words
    send(0, 4'd0, 4'b0000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    see("add", 32'h0020_81B3, 32'h0);
    send(0, 4'd0, 4'b1000, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0);
    see("sub", 32'h4073_02B3, 32'h4);
    send(0, 4'd1, 4'b1101, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3);
    see("srai", 32'h4031_5093, 32'h8);
    send(0, 4'd4, 4'b0000, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    see("beq", 32'hFE20_8EE3, 32'hC);
    send(0, 4'd7, 4'b0000, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000);
    see("lui", 32'h1234_5537, 32'h10);

    // more kinds, checked by the model
    send(0, 4'd2, 4'd0, 3'b010, 5'd4, 5'd5, 5'd0, 32'd8);
    send(0, 4'd3, 4'd0, 3'b001, 5'd0, 5'd9, 5'd11, -32'sd20);
    send(0, 4'd5, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(0, 4'd6, 4'd0, 3'd0, 5'd0, 5'd1, 5'd0, 32'd12);
    send(0, 4'd8, 4'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
    send(0, 4'd1, 4'b0110, 3'd0, 5'd8, 5'd8, 5'd0, -32'sd1);
    send(0, 4'd0, 4'b0011, 3'd0, 5'd9, 5'd10, 5'd11, 32'd0);
    send(0, 4'd4, 4'd0, 3'b111, 5'd0, 5'd3, 5'd4, 32'd4094);
    send(0, 4'd1, 4'b0001, 3'd0, 5'd2, 5'd3, 5'd0, 32'd31);

    // error cases
    clear();
    send(0, 4'hF, 4'd0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    @(negedge clk);
    chk("badkind_err", err, 1'b1);
    chk("badkind_code", err_code, 2'b01);
    chk("badkind_valid", inst_valid, 1'b0);
    chk("badkind_addr", inst_addr, 32'h0);
    @(negedge clk);
    chk("badkind_pulse", err, 1'b0);
    chk("badkind_hold", err_code, 2'b01);
    send(0, 4'd0, 4'b1001, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    @(negedge clk);
    chk("badfunct_code", err_code, 2'b10);
    send(0, 4'd3, 4'd0, 3'b011, 5'd0, 5'd1, 5'd2, 32'd0);
    send(0, 4'd1, 4'b1000, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
    send(0, 4'd4, 4'd0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8);
    send(0, 4'd7, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5001);
    @(negedge clk);
    if (IMM_CHK) begin
      chk("lui_imm_code", err_code, 2'b11);
      chk("lui_imm_valid", inst_valid, 1'b0);
    end else begin
      chk("lui_trunc_inst", inst, 32'h1234_5537);
      chk("lui_trunc_addr", inst_addr, 32'h0);
    end
    send(0, 4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    send(0, 4'd1, 4'b0101, 3'd0, 5'd1, 5'd2, 5'd0, 32'd40);

    // backpressure
    clear();
    @(posedge clk);
    #1 inst_ready = 1'b0;
    send(0, 4'd0, 4'b0000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    set_req(0, 4'd0, 4'b1000, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_inst", inst, 32'h0020_81B3);
      chk("bp_addr", inst_addr, 32'h0);
      chk("bp_ready", req_ready, 1'b0);
    end
    @(posedge clk);
    #1 inst_ready = 1'b1;
    wait_acc(0);
    see("bp_b", 32'h4073_02B3, 32'h4);
    send(0, 4'd1, 4'b1101, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3);
    see("bp_c", 32'h4031_5093, 32'h8);

    // toggling downstream readiness
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 inst_ready = i[0];
      send(0, 4'd1, 4'b0000, 3'd0, 5'(i), 5'd1, 5'd0, 32'(i * 7));
    end
    @(posedge clk);
    #1 inst_ready = 1'b1;

    // reset mid-stream
    @(posedge clk);
    #1 inst_ready = 1'b0;
    send(0, 4'd0, 4'b0111, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", inst_valid, 1'b0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_addr", inst_addr, 32'h0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_code", err_code, 2'd0);
    chk("mid_rst_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    inst_ready = 1'b1;

    // halting instance: stop on error, resume on clear, address wrap
    send(1, 4'hF, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    chk("h_err", h_err, 1'b1);
    chk("h_code", h_err_code, 2'b01);
    set_req(1, 4'd0, 4'b0000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("h_halt_ready", h_req_ready, 1'b0);
      chk("h_halt_valid", h_inst_valid, 1'b0);
    end
    @(posedge clk);
    #1 h_addr_clr = 1'b1;
    @(negedge clk);
    chk("h_clr_ready", h_req_ready, 1'b0);
    @(posedge clk);
    #1 h_addr_clr = 1'b0;
    wait_acc(1);
    @(negedge clk);
    chk("h_w0_inst", h_inst, 32'h0020_81B3);
    chk("h_w0_addr", h_inst_addr, 32'hFFFF_FFF8);
    send(1, 4'd0, 4'b1000, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0);
    @(negedge clk);
    chk("h_w1_inst", h_inst, 32'h4073_02B3);
    chk("h_w1_addr", h_inst_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("h_wrap_valid", h_inst_valid, 1'b0);
    chk("h_wrap_addr", h_inst_addr, 32'h0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
